// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_ctrl_pkg: state encodings, opcodes, ALU classes and datapath select codes
// shared by the multicycle MIPS control unit.
package mips_ctrl_pkg;
    typedef logic [3:0] state_t;
    localparam state_t S_FETCH     = 4'd0;
    localparam state_t S_DECODE    = 4'd1;
    localparam state_t S_MEMADDR   = 4'd2;
    localparam state_t S_MEMRD     = 4'd3;
    localparam state_t S_MEMWB     = 4'd4;
    localparam state_t S_MEMWR     = 4'd5;
    localparam state_t S_EXEC      = 4'd6;
    localparam state_t S_RWB       = 4'd7;
    localparam state_t S_IEXEC_ADD = 4'd8;
    localparam state_t S_IEXEC_IMM = 4'd9;
    localparam state_t S_IWB       = 4'd10;
    localparam state_t S_BRANCH    = 4'd11;
    localparam state_t S_JUMP      = 4'd12;
    localparam state_t S_JAL       = 4'd13;
    localparam state_t S_JR        = 4'd14;
    localparam state_t S_TRAP      = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_BGTZ = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2, ALU_IMM = 2'd3;
    localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
    localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
    localparam logic [1:0] M2R_ALU = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;
    localparam logic [1:0] SRCB_RT = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM4 = 2'd3;

    typedef enum logic [3:0] {
        C_LOAD, C_STORE, C_RTYPE, C_JR, C_BRANCH, C_IADD, C_IIMM, C_J, C_JAL, C_ILLEGAL
    } op_class_t;
endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: IR/memory inputs and datapath control outputs of the
// multicycle control unit; master is the controller, slave the datapath.
interface mips_multicycle_ctrl_if #(parameter int ALUOP_W = 2);
    logic [31:0]        instr;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         branch_type;
    logic [1:0]         pc_source;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
    logic [3:0]         state_o;

    modport master (
        input  instr, mem_ready,
        output pc_write, pc_write_cond, branch_type, pc_source, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal, state_o
    );
    modport slave (
        output instr, mem_ready,
        input  pc_write, pc_write_cond, branch_type, pc_source, iord, mem_read, mem_write,
               ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal, state_o
    );
endinterface

// File: rtl/mips_multicycle_ctrl_op_classify.sv
// mips_op_classify: maps the IR opcode/funct to an instruction class and the
// branch comparison type (0 beq, 1 bne, 2 bgtz).
module mips_op_classify
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output op_class_t   cls,
    output logic [1:0]  branch_type
);
    logic [5:0] op;
    assign op = instr[31:26];
    assign branch_type = op == OP_BNE ? 2'd1 : op == OP_BGTZ ? 2'd2 : 2'd0;

    always_comb begin
        cls = C_ILLEGAL;
        case (op)
            OP_LW, OP_LB, OP_LH:           cls = C_LOAD;
            OP_SW, OP_SB, OP_SH:           cls = C_STORE;
            OP_RTYPE:                      cls = instr[5:0] == FUNCT_JR ? C_JR : C_RTYPE;
            OP_BEQ, OP_BNE, OP_BGTZ:       cls = C_BRANCH;
            OP_ADDI:                       cls = C_IADD;
            OP_ANDI, OP_ORI, OP_SLTI:      cls = C_IIMM;
            OP_J:                          cls = C_J;
            OP_JAL:                        cls = C_JAL;
            default:                       cls = C_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: registered FSM sequencing fetch/decode/execute/memory/
// writeback with a memory-ready handshake and illegal-opcode trap.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W       = 2,
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit TRAP_ILLEGAL  = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    mips_multicycle_ctrl_if.master bus
);
    state_t    st, nx;
    op_class_t cls;
    logic [1:0] bt, aop;
    logic      ready;

    mips_op_classify u_classify (.instr(bus.instr), .cls(cls), .branch_type(bt));

    assign ready = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk)
        st <= !rst ? S_FETCH : nx;

    always_comb begin
        nx = S_FETCH;
        case (st)
            S_FETCH:   nx = ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (cls)
                    C_LOAD, C_STORE: nx = S_MEMADDR;
                    C_RTYPE:         nx = S_EXEC;
                    C_JR:            nx = S_JR;
                    C_BRANCH:        nx = S_BRANCH;
                    C_IADD:          nx = S_IEXEC_ADD;
                    C_IIMM:          nx = S_IEXEC_IMM;
                    C_J:             nx = S_JUMP;
                    C_JAL:           nx = S_JAL;
                    default:         nx = S_TRAP;
                endcase
            S_MEMADDR: nx = cls == C_LOAD ? S_MEMRD : S_MEMWR;
            S_MEMRD:   nx = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   nx = ready ? S_FETCH : S_MEMWR;
            S_EXEC:    nx = S_RWB;
            S_IEXEC_ADD, S_IEXEC_IMM: nx = S_IWB;
            S_TRAP:    nx = TRAP_ILLEGAL ? S_TRAP : S_FETCH;
            default:   nx = S_FETCH;
        endcase
    end

    // every output is qualified by rst so an asserted reset silences the datapath at once
    assign bus.state_o       = rst ? st : S_FETCH;
    assign bus.pc_write      = rst && ((st == S_FETCH && ready) || st == S_JUMP || st == S_JAL || st == S_JR);
    assign bus.ir_write      = rst && st == S_FETCH && ready;
    assign bus.mem_write     = rst && st == S_MEMWR && ready;
    assign bus.mem_read      = rst && (st == S_FETCH || st == S_MEMRD);
    assign bus.iord          = rst && (st == S_MEMRD || st == S_MEMWR);
    assign bus.pc_write_cond = rst && st == S_BRANCH;
    assign bus.branch_type   = rst && st == S_BRANCH ? bt : 2'd0;
    assign bus.reg_write     = rst && (st == S_MEMWB || st == S_RWB || st == S_IWB || st == S_JAL);
    assign bus.illegal       = rst && st == S_TRAP;
    assign bus.alu_src_a     = rst && (st == S_MEMADDR || st == S_EXEC || st == S_IEXEC_ADD ||
                                       st == S_IEXEC_IMM || st == S_BRANCH);
    assign bus.pc_source     = !rst ? PC_ALU : st == S_BRANCH ? PC_ALUOUT :
                               (st == S_JUMP || st == S_JAL) ? PC_JUMP : st == S_JR ? PC_RS : PC_ALU;
    assign bus.reg_dst       = !rst ? RD_RT : st == S_RWB ? RD_RD : st == S_JAL ? RD_RA : RD_RT;
    assign bus.mem_to_reg    = !rst ? M2R_ALU : st == S_MEMWB ? M2R_MDR : st == S_JAL ? M2R_PC : M2R_ALU;
    assign bus.alu_src_b     = !rst ? SRCB_RT : st == S_FETCH ? SRCB_4 : st == S_DECODE ? SRCB_IMM4 :
                               (st == S_MEMADDR || st == S_IEXEC_ADD || st == S_IEXEC_IMM) ? SRCB_IMM : SRCB_RT;
    assign aop               = !rst ? ALU_ADD : st == S_EXEC ? ALU_FUNCT : st == S_BRANCH ? ALU_SUB :
                               st == S_IEXEC_IMM ? ALU_IMM : ALU_ADD;
    assign bus.alu_op        = ALUOP_W'(aop);
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed checks of the multicycle control FSM, with a
// trapping and a non-trapping instance driven by identical stimulus.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.ALUOP_W(2)) if0 ();
    mips_multicycle_ctrl_if #(.ALUOP_W(2)) if1 ();

    mips_multicycle_ctrl #(.ALUOP_W(2), .MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0));
    mips_multicycle_ctrl #(.ALUOP_W(2), .MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1));

    // packed control word: {pw, pwc, bt[2], ps[2], iord, mr, mw, irw, rw, rd[2], m2r[2], asa, asb[2], aop[2], ill}
    localparam logic [20:0] E_ZERO     = 21'd0;
    localparam logic [20:0] E_FETCH_RDY = {1'b1,1'b0,2'd0,2'd0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,2'd0,1'b0,2'd1,2'd0,1'b0};
    localparam logic [20:0] E_FETCH_W  = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd1,2'd0,1'b0};
    localparam logic [20:0] E_DECODE   = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd3,2'd0,1'b0};
    localparam logic [20:0] E_MEMADDR  = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,2'd0,1'b0};
    localparam logic [20:0] E_MEMRD    = {1'b0,1'b0,2'd0,2'd0,1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0};
    localparam logic [20:0] E_MEMWB    = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd1,1'b0,2'd0,2'd0,1'b0};
    localparam logic [20:0] E_MEMWR_W  = {1'b0,1'b0,2'd0,2'd0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0};
    localparam logic [20:0] E_MEMWR_R  = {1'b0,1'b0,2'd0,2'd0,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0};
    localparam logic [20:0] E_EXEC     = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,2'd2,1'b0};
    localparam logic [20:0] E_RWB      = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd1,2'd0,1'b0,2'd0,2'd0,1'b0};
    localparam logic [20:0] E_IADD     = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,2'd0,1'b0};
    localparam logic [20:0] E_IIMM     = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd2,2'd3,1'b0};
    localparam logic [20:0] E_IWB      = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0};
    localparam logic [20:0] E_BNE      = {1'b0,1'b1,2'd1,2'd1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b1,2'd0,2'd1,1'b0};
    localparam logic [20:0] E_JAL      = {1'b1,1'b0,2'd0,2'd2,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,2'd2,1'b0,2'd0,2'd0,1'b0};
    localparam logic [20:0] E_JR       = {1'b1,1'b0,2'd0,2'd3,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b0};
    localparam logic [20:0] E_TRAP     = {1'b0,1'b0,2'd0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd0,1'b1};

    function automatic logic [20:0] pk0();
        return {if0.pc_write, if0.pc_write_cond, if0.branch_type, if0.pc_source, if0.iord, if0.mem_read,
                if0.mem_write, if0.ir_write, if0.reg_write, if0.reg_dst, if0.mem_to_reg, if0.alu_src_a,
                if0.alu_src_b, if0.alu_op, if0.illegal};
    endfunction

    function automatic logic [20:0] pk1();
        return {if1.pc_write, if1.pc_write_cond, if1.branch_type, if1.pc_source, if1.iord, if1.mem_read,
                if1.mem_write, if1.ir_write, if1.reg_write, if1.reg_dst, if1.mem_to_reg, if1.alu_src_a,
                if1.alu_src_b, if1.alu_op, if1.illegal};
    endfunction

    task automatic drive(input logic [31:0] i, input logic r);
        if0.instr = i; if0.mem_ready = r;
        if1.instr = i; if1.mem_ready = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(32'h0, 1'b0);
        rst = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if (if0.state_o !== 4'd0 || pk0() !== E_ZERO) begin
            errors++;
            $display("FAIL reset_hold: got state=%0d ctl=%h, want state=0 ctl=%h", if0.state_o, pk0(), E_ZERO);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (if0.state_o !== 4'd0 || pk0() !== E_FETCH_W) begin
            errors++;
            $display("FAIL reset_release: got state=%0d ctl=%h, want state=0 ctl=%h", if0.state_o, pk0(), E_FETCH_W);
        end
        // walk a store into MEMWR, stall, then reset in the middle of it
        drive(32'hAD090004, 1'b1);
        next_cycle();
        drive(32'hAD090004, 1'b0);
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if (if0.state_o !== 4'd5 || pk0() !== E_MEMWR_W) begin
            errors++;
            $display("FAIL reset_pre_memwr: got state=%0d ctl=%h, want state=5 ctl=%h", if0.state_o, pk0(), E_MEMWR_W);
        end
        next_cycle();
        rst = 1'b0;
        drive(32'hAD090004, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (if0.state_o !== 4'd0 || pk0() !== E_ZERO || if0.mem_write !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_memwr cyc%0d: got state=%0d ctl=%h mw=%b, want state=0 ctl=%h mw=0",
                         k, if0.state_o, pk0(), if0.mem_write, E_ZERO);
            end
            next_cycle();
        end
        rst = 1'b1;
        drive(32'hAD090004, 1'b0);
        @(negedge clk);
        checks++;
        if (if0.state_o !== 4'd0 || if0.mem_read !== 1'b1 || pk0() !== E_FETCH_W) begin
            errors++;
            $display("FAIL reset_after_memwr: got state=%0d ctl=%h, want state=0 ctl=%h", if0.state_o, pk0(), E_FETCH_W);
        end
    endtask

    task automatic test_rtype();
        logic [3:0]  st[4] = '{4'd0, 4'd1, 4'd6, 4'd7};
        logic [20:0] v[4]  = '{E_FETCH_RDY, E_DECODE, E_EXEC, E_RWB};
        drive(32'h012A4020, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (if0.state_o !== st[k] || pk0() !== v[k]) begin
                errors++;
                $display("FAIL rtype cyc%0d: got state=%0d ctl=%h, want state=%0d ctl=%h", k, if0.state_o, pk0(), st[k], v[k]);
            end
            next_cycle();
        end
        checks++;
        if (if0.state_o !== 4'd0) begin
            errors++;
            $display("FAIL rtype_done: got state=%0d, want state=0", if0.state_o);
        end
    endtask

    task automatic test_load_stall();
        logic [3:0]  st[8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic        rd[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [20:0] v[8]  = '{E_FETCH_RDY, E_DECODE, E_MEMADDR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
        for (int k = 0; k < 8; k++) begin
            drive(32'h8D090004, rd[k]);
            @(negedge clk);
            checks++;
            if (if0.state_o !== st[k] || pk0() !== v[k]) begin
                errors++;
                $display("FAIL load_stall cyc%0d: got state=%0d ctl=%h, want state=%0d ctl=%h", k, if0.state_o, pk0(), st[k], v[k]);
            end
            next_cycle();
        end
        drive(32'h8D090004, 1'b0);
        @(negedge clk);
        checks++;
        if (if0.state_o !== 4'd0 || pk0() !== E_FETCH_W) begin
            errors++;
            $display("FAIL load_done: got state=%0d ctl=%h, want state=0 ctl=%h", if0.state_o, pk0(), E_FETCH_W);
        end
    endtask

    task automatic test_store();
        logic [3:0]  st[5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
        logic        rd[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [20:0] v[5]  = '{E_FETCH_RDY, E_DECODE, E_MEMADDR, E_MEMWR_W, E_MEMWR_R};
        for (int k = 0; k < 5; k++) begin
            drive(32'hAD090004, rd[k]);
            @(negedge clk);
            checks++;
            if (if0.state_o !== st[k] || pk0() !== v[k]) begin
                errors++;
                $display("FAIL store cyc%0d: got state=%0d ctl=%h, want state=%0d ctl=%h", k, if0.state_o, pk0(), st[k], v[k]);
            end
            next_cycle();
        end
        checks++;
        if (if0.state_o !== 4'd0) begin
            errors++;
            $display("FAIL store_done: got state=%0d, want state=0", if0.state_o);
        end
    endtask

    task automatic test_immediate();
        logic [31:0] ins[2] = '{32'h21090005, 32'h35090005};
        logic [3:0]  xs[2]  = '{4'd8, 4'd9};
        logic [20:0] xv[2]  = '{E_IADD, E_IIMM};
        for (int n = 0; n < 2; n++) begin
            drive(ins[n], 1'b1);
            next_cycle();
            next_cycle();
            @(negedge clk);
            checks++;
            if (if0.state_o !== xs[n] || pk0() !== xv[n]) begin
                errors++;
                $display("FAIL imm%0d_exec: got state=%0d ctl=%h, want state=%0d ctl=%h", n, if0.state_o, pk0(), xs[n], xv[n]);
            end
            next_cycle();
            @(negedge clk);
            checks++;
            if (if0.state_o !== 4'd10 || pk0() !== E_IWB) begin
                errors++;
                $display("FAIL imm%0d_wb: got state=%0d ctl=%h, want state=10 ctl=%h", n, if0.state_o, pk0(), E_IWB);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch_jumps();
        logic [31:0] ins[3] = '{32'h15090003, 32'h0C000010, 32'h03E00008};
        logic [3:0]  xs[3]  = '{4'd11, 4'd13, 4'd14};
        logic [20:0] xv[3]  = '{E_BNE, E_JAL, E_JR};
        for (int n = 0; n < 3; n++) begin
            drive(ins[n], 1'b1);
            @(negedge clk);
            checks++;
            if (if0.state_o !== 4'd0 || pk0() !== E_FETCH_RDY) begin
                errors++;
                $display("FAIL ctl%0d_fetch: got state=%0d ctl=%h, want state=0 ctl=%h", n, if0.state_o, pk0(), E_FETCH_RDY);
            end
            next_cycle();
            next_cycle();
            @(negedge clk);
            checks++;
            if (if0.state_o !== xs[n] || pk0() !== xv[n]) begin
                errors++;
                $display("FAIL ctl%0d_exec: got state=%0d ctl=%h, want state=%0d ctl=%h", n, if0.state_o, pk0(), xs[n], xv[n]);
            end
            next_cycle();
            checks++;
            if (if0.state_o !== 4'd0) begin
                errors++;
                $display("FAIL ctl%0d_done: got state=%0d, want state=0", n, if0.state_o);
            end
        end
    endtask

    task automatic test_illegal();
        drive(32'hFC000000, 1'b1);
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (if0.state_o !== 4'd15 || pk0() !== E_TRAP || if1.state_o !== 4'd15 || pk1() !== E_TRAP) begin
            errors++;
            $display("FAIL trap_entry: got s0=%0d c0=%h s1=%0d c1=%h, want 15/%h both", if0.state_o, pk0(), if1.state_o, pk1(), E_TRAP);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (if0.state_o !== 4'd15 || pk0() !== E_TRAP) begin
                errors++;
                $display("FAIL trap_hold cyc%0d: got state=%0d ctl=%h, want state=15 ctl=%h", k, if0.state_o, pk0(), E_TRAP);
            end
            if (k == 0) begin
                checks++;
                if (if1.state_o !== 4'd0 || pk1() !== E_FETCH_RDY) begin
                    errors++;
                    $display("FAIL trap_pulse: got state=%0d ctl=%h, want state=0 ctl=%h", if1.state_o, pk1(), E_FETCH_RDY);
                end
            end
        end
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        drive(32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (if0.state_o !== 4'd0 || pk0() !== E_FETCH_W) begin
            errors++;
            $display("FAIL trap_reset: got state=%0d ctl=%h, want state=0 ctl=%h", if0.state_o, pk0(), E_FETCH_W);
        end
    endtask

    initial begin
        test_reset();
        next_cycle();
        test_rtype();
        test_load_stall();
        next_cycle();
        test_store();
        test_immediate();
        test_branch_jumps();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS control unit. Replaces the opcode-decoded control with a registered FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It waits on a memory-ready handshake and traps illegal opcodes. It sits between the instruction register (IR) and the datapath muxes, register file, PC and unified memory port.

Parameters:
ALUOP_W, 2, width of alu_op; must be >=2. Codes are ADD=0, SUB=1, FUNCT=2, IMM=3, zero-extended to ALUOP_W.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = memory completes in one cycle and mem_ready is ignored.
TRAP_ILLEGAL, 1, 1 = an illegal opcode locks the FSM in TRAP; 0 = an illegal opcode pulses illegal for one cycle and returns to FETCH.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-low reset
instr  in  32  current IR contents (opcode [31:26], funct [5:0])
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load qualified by the datapath branch compare
branch_type  out  2  0 beq, 1 bne, 2 bgtz
pc_source  out  2  0 ALU result, 1 ALUOut (branch target), 2 jump target, 3 rs (jr)
iord  out  1  0 PC address, 1 ALUOut address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_write  out  1  register file write enable
reg_dst  out  2  0 rt, 1 rd, 2 $31
mem_to_reg  out  2  0 ALUOut, 1 MDR, 2 PC
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  0 rt, 1 const 4, 2 sign-ext imm, 3 sign-ext imm<<2
alu_op  out  ALUOP_W  ALU class code
illegal  out  1  illegal-opcode flag
state_o  out  4  current state, for debug

Behaviour:
- Reset: rst=0 at a rising edge sets the state to FETCH. While rst=0, every output is forced to 0. Reset mid-instruction abandons the instruction; no PC, register or memory write occurs.
- Outputs are Moore-decoded from state. The only exceptions are pc_write, ir_write and mem_write, which are also gated by mem_ready where noted. Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_source=0.
  - If mem_ready=1 (or MEM_HANDSHAKE=0): ir_write=1, pc_write=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD. Next state by opcode:
  - 100011/100000/100001 (lw/lb/lh) -> MEMADDR
  - 101011/101000/101001 (sw/sb/sh) -> MEMADDR
  - 000000 with funct=001000 -> JR
  - 000000 with any other funct -> EXEC
  - 000100/000101/000111 -> BRANCH
  - 001000 -> IEXEC_ADD
  - 001100/001101/001010 -> IEXEC_IMM
  - 000010 -> JUMP
  - 000011 -> JAL
  - anything else -> TRAP
- MEMADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. Next MEMRD for loads, MEMWR for stores.
- MEMRD: iord=1, mem_read=1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
- MEMWR: iord=1. mem_write=1 only in the cycle mem_ready=1 (every cycle if MEM_HANDSHAKE=0); that cycle, next FETCH.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=FUNCT. Next RWB.
- RWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH.
- IEXEC_ADD / IEXEC_IMM: alu_src_a=1, alu_src_b=2, alu_op=ADD / IMM respectively. Next IWB.
- IWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_write_cond=1, pc_source=1. branch_type is 0/1/2 for opcode 000100/000101/000111. Next FETCH.
- JUMP: pc_write=1, pc_source=2. Next FETCH.
- JAL: pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2. Next FETCH. The PC already holds PC+4, so the link value is correct at the edge.
- JR: pc_write=1, pc_source=3. Next FETCH.
- TRAP: illegal=1, all write strobes 0.
  - TRAP_ILLEGAL=1: hold in TRAP until reset.
  - TRAP_ILLEGAL=0: one cycle in TRAP, then FETCH.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR. A stall of any length holds all outputs stable.
- Latency with zero wait states, in cycles: lw 5, sw 4, R-type 4, I-ALU 4, branch 3, j 3, jal 3, jr 3.
- Unused state encodings go to FETCH on the next edge.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state enum (4-bit)
  - opcode constants and FUNCT_JR
  - ALU op codes
  - select codes for pc_source, reg_dst, mem_to_reg and alu_src_b
- One combinational sub-module, mips_op_classify: instr -> class (LOAD, STORE, RTYPE, JR, BRANCH, IADD, IIMM, J, JAL, ILLEGAL) plus branch_type.

Test Plan:
- Reset: rst=0 for 2 cycles mid-MEMWR -> all outputs 0 and no mem_write; after rst=1 the state is FETCH with mem_read=1.
- R-type: add (0x012A4020), mem_ready=1 -> 4 cycles FETCH/DECODE/EXEC/RWB; RWB has reg_write=1, reg_dst=1, alu_op=2 in EXEC.
- Load stall: lw (0x8D090004), mem_ready low 3 cycles in MEMRD -> state held 3 cycles, mem_read=1 throughout, then MEMWB with mem_to_reg=1. Total 8 cycles.
- Branch: bne (0x15090003) -> BRANCH has pc_write_cond=1, branch_type=1, pc_source=1, alu_op=1.
- Jumps: jal (0x0C000010) -> JAL with reg_dst=2, mem_to_reg=2, reg_write=1, pc_source=2; jr $31 (0x03E00008) -> JR with pc_source=3.
- Illegal: opcode 111111 with TRAP_ILLEGAL=1 -> illegal held high with no writes until reset; with TRAP_ILLEGAL=0 -> one-cycle pulse, then FETCH.
